// File: rtl/arb_requester.sv
// Requester-side agent for a round-robin bus arbiter: queues transfer commands,
// raises req, and emits a burst of incrementing data beats once granted.
//
// state   | meaning
// IDLE    | req low; waiting for a queued command
// REQ     | req high; waiting for gnt, bounded by TIMEOUT cycles
// XFER    | granted; one beat per cycle, base+k
// RELEASE | req forced low for one cycle so the arbiter can rotate
module arb_requester #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              req,
  input  logic              gnt,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err,
  output logic              gnt_lost_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [7:0]  WAIT_LOAD = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]              state;
  logic [LEN_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [LEN_W-1:0]        head_len;
  logic [DATA_W-1:0]       head_data;
  logic [7:0]              wait_cnt;
  logic [LEN_W-1:0]        beat;
  logic [LEN_W-1:0]        len;
  logic [DATA_W-1:0]       base;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = ~full & rst;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_REQ) & gnt;
  assign {head_len, head_data} = mem[rd_ptr];
  assign busy      = (state != S_IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_len, cmd_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Wait timer is a down-counter: loaded on REQ entry, timeout at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      req          <= 1'b0;
      bus_valid    <= 1'b0;
      bus_data     <= '0;
      bus_last     <= 1'b0;
      timeout_err  <= 1'b0;
      gnt_lost_err <= 1'b0;
      wait_cnt     <= '0;
      beat         <= '0;
      len          <= '0;
      base         <= '0;
    end else begin
      timeout_err  <= 1'b0;
      gnt_lost_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state    <= S_REQ;
            req      <= 1'b1;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_REQ: begin
          if (gnt) begin
            state     <= S_XFER;
            beat      <= '0;
            len       <= head_len;
            base      <= head_data;
            bus_valid <= 1'b1;
            bus_data  <= head_data;
            bus_last  <= (head_len == '0);
          end else if (wait_cnt == '0) begin
            state       <= S_RELEASE;
            req         <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        S_XFER: begin
          if (!gnt) begin
            state        <= S_RELEASE;
            req          <= 1'b0;
            bus_valid    <= 1'b0;
            bus_last     <= 1'b0;
            gnt_lost_err <= 1'b1;
          end else if (beat == len) begin
            state     <= S_RELEASE;
            req       <= 1'b0;
            bus_valid <= 1'b0;
            bus_last  <= 1'b0;
          end else begin
            beat     <= beat + LEN_W'(1);
            bus_data <= base + DATA_W'(beat) + DATA_W'(1);
            bus_last <= ((beat + LEN_W'(1)) == len);
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: table-driven directed vectors, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_arb_requester;

  localparam int TIMEOUT    = 15;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_len = '0;
  logic [7:0] cmd_data = '0;
  logic       req;
  logic       gnt = 1'b0;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic       busy;
  logic       timeout_err;
  logic       gnt_lost_err;

  always #5 clk = ~clk;

  arb_requester #(.DATA_W(8), .LEN_W(4), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .req(req), .gnt(gnt),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .timeout_err(timeout_err), .gnt_lost_err(gnt_lost_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    gnt = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic       cv;
    logic [3:0] len;
    logic [7:0] data;
    logic       g;
    logic       e_req;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic       e_ready;
  } vec_t;

  typedef struct packed {
    logic [3:0] len;
    logic [7:0] data;
  } cmd_t;

  vec_t tbl [18];

  cmd_t q[$];
  cmd_t cur;
  cmd_t pend;
  int   k, waits, low_run, qsize_prev, mode, n, lasts;
  logic p_r, p_v, gnt_e, push, t_seen;
  logic exp_r, exp_v, exp_last, exp_to, exp_gl, exp_busy;
  logic [7:0] exp_d;

  initial begin
    tbl = '{
      // single command: len=2, data=0x10
      '{1'b1, 4'd2, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
      // back-to-back single-beat commands with gnt held high
      '{1'b1, 4'd0, 8'h21, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b1, 4'd0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}
    };

    // reset state
    step();
    chk_b("rst_req", req, 1'b0);
    chk_b("rst_valid", bus_valid, 1'b0);
    chk_d("rst_data", bus_data, 8'h00);
    chk_b("rst_last", bus_last, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_ready", cmd_ready, 1'b0);
    chk_b("rst_to", timeout_err, 1'b0);
    chk_b("rst_gl", gnt_lost_err, 1'b0);
    do_reset();
    #1 chk_b("rst_ready_after", cmd_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < $size(tbl); i++) begin
      cmd_valid = tbl[i].cv;
      cmd_len   = tbl[i].len;
      cmd_data  = tbl[i].data;
      gnt       = tbl[i].g;
      step();
      chk_b($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
      chk_b($sformatf("tbl%0d_valid", i), bus_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk_d($sformatf("tbl%0d_data", i), bus_data, tbl[i].e_data);
        chk_b($sformatf("tbl%0d_last", i), bus_last, tbl[i].e_last);
      end
      chk_b($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk_b($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].e_ready);
      chk_b($sformatf("tbl%0d_errs", i), timeout_err | gnt_lost_err, 1'b0);
    end

    // timeout and retry
    gnt = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd1; cmd_data = 8'h40;
    step();
    cmd_valid = 1'b0;
    step();
    chk_b("to_req_up", req, 1'b1);
    n = 1;
    t_seen = 1'b0;
    for (int i = 0; i < 40 && req; i++) begin
      step();
      if (req) n++;
      else t_seen = timeout_err;
    end
    chk_i("to_req_cycles", n, TIMEOUT);
    chk_b("to_pulse", t_seen, 1'b1);
    step();
    chk_b("to_pulse_width", timeout_err, 1'b0);
    chk_b("to_req_low2", req, 1'b0);
    step();
    chk_b("to_retry_req", req, 1'b1);
    gnt = 1'b1;
    step();
    chk_b("to_retry_valid", bus_valid, 1'b1);
    chk_d("to_retry_b0", bus_data, 8'h40);
    step();
    chk_d("to_retry_b1", bus_data, 8'h41);
    chk_b("to_retry_last", bus_last, 1'b1);
    step();
    chk_b("to_retry_end", bus_valid, 1'b0);
    chk_b("to_no_gl", gnt_lost_err, 1'b0);
    gnt = 1'b0;
    step();
    chk_b("to_idle", busy, 1'b0);

    // grant lost at beat 3
    gnt = 1'b1;
    cmd_valid = 1'b1; cmd_len = 4'd7; cmd_data = 8'h80;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk_d("gl_beat0", bus_data, 8'h80);
    step(); step(); step();
    chk_d("gl_beat3", bus_data, 8'h83);
    gnt = 1'b0;
    step();
    chk_b("gl_pulse", gnt_lost_err, 1'b1);
    chk_b("gl_valid_low", bus_valid, 1'b0);
    chk_b("gl_req_low", req, 1'b0);
    chk_b("gl_no_to", timeout_err, 1'b0);
    step();
    chk_b("gl_pulse_width", gnt_lost_err, 1'b0);
    chk_b("gl_idle", busy, 1'b0);
    gnt = 1'b1;
    repeat (4) step();
    chk_b("gl_no_replay", req, 1'b0);
    gnt = 1'b0;

    // full queue and data wraparound
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_len   = (i == 0) ? 4'd3 : 4'd0;
      cmd_data  = (i == 0) ? 8'hFE : 8'(i);
      chk_b($sformatf("fq_ready%0d", i), cmd_ready, i < 4);
      step();
    end
    cmd_valid = 1'b0;
    gnt = 1'b1;
    step();
    chk_b("fq_valid", bus_valid, 1'b1);
    chk_d("fq_b0", bus_data, 8'hFE);
    chk_b("fq_ready_freed", cmd_ready, 1'b1);
    step();
    chk_d("fq_b1", bus_data, 8'hFF);
    step();
    chk_d("fq_b2", bus_data, 8'h00);
    chk_b("fq_b2_last", bus_last, 1'b0);
    step();
    chk_d("fq_b3", bus_data, 8'h01);
    chk_b("fq_b3_last", bus_last, 1'b1);
    lasts = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      step();
      if (bus_valid && bus_last) lasts++;
    end
    chk_i("fq_drain_bursts", lasts, 3);
    chk_b("fq_drained", busy, 1'b0);
    gnt = 1'b0;

    // reset during beat 2
    gnt = 1'b1;
    cmd_valid = 1'b1; cmd_len = 4'd5; cmd_data = 8'h30;
    step();
    cmd_len = 4'd0; cmd_data = 8'h55;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    chk_d("mr_beat2", bus_data, 8'h32);
    #2 rst = 1'b0;
    #1;
    chk_b("mr_req", req, 1'b0);
    chk_b("mr_valid", bus_valid, 1'b0);
    chk_d("mr_data", bus_data, 8'h00);
    chk_b("mr_last", bus_last, 1'b0);
    chk_b("mr_busy", busy, 1'b0);
    chk_b("mr_ready", cmd_ready, 1'b0);
    chk_b("mr_errs", timeout_err | gnt_lost_err, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk_b("mr_ready_after", cmd_ready, 1'b1);
    chk_b("mr_empty", busy, 1'b0);
    repeat (3) step();
    chk_b("mr_no_req", req, 1'b0);
    chk_b("mr_no_err", timeout_err | gnt_lost_err, 1'b0);
    gnt = 1'b0;

    // randomized run against a transaction-level model
    do_reset();
    q.delete();
    p_r = 1'b0; p_v = 1'b0; low_run = 2; waits = 0; k = 0; mode = 0;
    cur = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 40 == 0) mode = $urandom_range(0, 2);
      cmd_valid = ($urandom_range(0, 9) < 4);
      pend.len  = 4'($urandom_range(0, 5));
      pend.data = 8'($urandom);
      cmd_len   = pend.len;
      cmd_data  = pend.data;
      case (mode)
        0:       gnt = ($urandom_range(0, 19) != 0);
        1:       gnt = 1'b0;
        default: gnt = 1'($urandom_range(0, 1));
      endcase
      qsize_prev = q.size();
      push  = cmd_valid && (qsize_prev < FIFO_DEPTH);
      gnt_e = gnt;
      step();

      exp_to = 1'b0; exp_gl = 1'b0; exp_v = 1'b0; exp_last = 1'b0; exp_d = '0; exp_r = 1'b0;
      if (!p_r) begin
        // low phase: a request may start only once req has been low 2 cycles
        exp_r = (low_run >= 2) && (qsize_prev > 0);
        if (exp_r) waits = 0;
      end else if (!p_v) begin
        if (gnt_e) begin
          cur = q.pop_front();
          k = 0;
          exp_r = 1'b1; exp_v = 1'b1; exp_d = cur.data; exp_last = (cur.len == 0);
        end else begin
          waits++;
          if (waits == TIMEOUT) exp_to = 1'b1;
          else exp_r = 1'b1;
        end
      end else begin
        if (!gnt_e) exp_gl = 1'b1;
        else if (k != int'(cur.len)) begin
          k++;
          exp_r = 1'b1; exp_v = 1'b1;
          exp_d = cur.data + 8'(k);
          exp_last = (k == int'(cur.len));
        end
      end
      if (push) q.push_back(pend);
      exp_busy = p_r || exp_r || (q.size() > 0);

      chk_b("rnd_req", req, exp_r);
      chk_b("rnd_valid", bus_valid, exp_v);
      if (exp_v) begin
        chk_d("rnd_data", bus_data, exp_d);
        chk_b("rnd_last", bus_last, exp_last);
      end
      chk_b("rnd_to", timeout_err, exp_to);
      chk_b("rnd_gl", gnt_lost_err, exp_gl);
      chk_b("rnd_busy", busy, exp_busy);
      chk_b("rnd_ready", cmd_ready, q.size() < FIFO_DEPTH);

      low_run = exp_r ? 0 : ((low_run < 10) ? low_run + 1 : low_run);
      p_r = exp_r;
      p_v = exp_v;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
